seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Display scan scheduler for the 4-digit, active-low seven-segment display on the vending board. Shares the display between two clients: channel A, the live credit value, and channel B, a requested message such as returned change. Time-multiplexes the four digits with a blanking interval per slot, so the display stays free of ghosting. Drives the digit nibble for the HEX_7seg decoder, plus the decimal point and the anode lines.

## Interface
- DIGIT_CYCLES, 1024: CLK cycles per digit slot (≥ BLANK_CYCLES+2).
- BLANK_CYCLES, 64: cycles at the start of each slot with all anodes off.
- HOLD_FRAMES, 200: complete frames (4 slots each) that a channel B message stays on the display.
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- a_val  in  16  channel A, four nibbles; [3:0] is digit 0 (rightmost).
- a_dp  in  4  channel A decimal points, 1 = lit, bit i goes with digit i.
- b_req  in  1  channel B request; held by the requester until b_ack.
- b_val  in  16  channel B nibbles; sampled on the b_ack cycle.
- b_dp  in  4  channel B decimal points.
- b_ack  out  1  one-cycle pulse: b_val/b_dp captured.
- digit  out  4  nibble to the decoder.
- dp  out  1  active-low decimal point (1 = off).
- AN  out  4  active-low anodes; at most one bit low.
- owner  out  1  0 = channel A displayed, 1 = channel B displayed.

## Operation
- Slot counter runs 0..DIGIT_CYCLES-1. At the wrap, the digit index advances 0→1→2→3→0.
- A frame ends when the index wraps 3→0. Frame boundary = the cycle on which the slot counter wraps with index 3.
- Within a slot:
  - Counter < BLANK_CYCLES: AN=4'b1111 and dp=1.
  - Otherwise: AN[index]=0, and digit/dp come from the owner's source nibble index.
- Channel A is sampled live every cycle. Channel B is shown from internal latches only.
- FSM states:
  - SHOW_A: b_req=1 → b_ack pulse, latch b_val/b_dp, go to PEND_B.
  - PEND_B: wait; at the frame boundary set owner=1, clear the frame count, go to SHOW_B.
  - SHOW_B: count frame boundaries. On the HOLD_FRAMES-th boundary set owner=0 and go to SHOW_A.
- b_req in PEND_B or SHOW_B is not acknowledged. The requester keeps it high and is served after the return to SHOW_A; the earliest b_ack is the cycle after owner drops.
- b_req during reset, or on the reset-release cycle: no ack.
- Owner switches only at frame boundaries, so frames are never torn.
- Nibble values A–F pass through unchanged (hex display).

## Timing
- Reset values:
  - AN=4'b1111, dp=1, digit=0, b_ack=0, owner=0.
  - Slot counter=0, index=0, state SHOW_A, frame count=0, B latches=0.
- Outputs are registered: AN, digit and dp reflect the counter/index value of the previous cycle (1-cycle latency).
- The first AN low occurs at cycle BLANK_CYCLES+1 after reset deasserts.
- b_ack is asserted the cycle after b_req is sampled high in SHOW_A; it is exactly one cycle wide.
- Displaying channel B:
  - owner rises 1 cycle after the frame boundary following b_ack.
  - owner falls 1 cycle after the HOLD_FRAMES-th boundary.
- A mid-operation RST returns all outputs to reset values on the next edge and discards a latched B message.

## Configuration
- SEG_SCAN_LZ_BLANK_EN defined: leading-zero blanking.
  - For the owner's value, digits 3..1 that are 0 and have no higher non-zero digit keep AN=1111 for the whole slot.
  - Digit 0 is never blanked.
  - A digit whose dp bit is set is never blanked.
- Not defined: all four digits are always driven, and zeros are shown.

## Structure
- Package seg_scan_pkg:
  - state enum (SHOW_A, PEND_B, SHOW_B)
  - NUM_DIGITS=4, AN_OFF=4'b1111, DP_OFF=1'b1
- Sub-module seg_slot_timer: slot counter, digit index and frame-boundary strobe, parameterised by DIGIT_CYCLES.
- The FSM, latches and output mux stay in seg_scan_ctrl.

## Test plan
All scenarios use DIGIT_CYCLES=8, BLANK_CYCLES=2, HOLD_FRAMES=2.
- Reset scan:
  - Stimulus: a_val=16'h0015, a_dp=0.
  - Response: AN sequence 1111,1111,1110×6 for digit 0 (digit=5), then the same pattern for 1101 (digit=1), 1011 (0), 0111 (0). dp=1 throughout.
- B request:
  - Stimulus: b_req held high at cycle 5 with b_val=16'h0010.
  - Response: b_ack high for one cycle only. owner=1 one cycle after cycle-32 boundary, held for 64 cycles, then 0. digit=0/1 from B while owner=1.
- Busy request:
  - Stimulus: second b_req during SHOW_B.
  - Response: no b_ack until the cycle after owner falls, then b_ack and a new PEND_B.
- Reset mid-message:
  - Stimulus: RST for 1 cycle in SHOW_B.
  - Response: owner=0, AN=1111 next cycle, a_val is shown after restart.
- Leading-zero blanking (SEG_SCAN_LZ_BLANK_EN):
  - Stimulus: a_val=16'h0005, a_dp=4'b0100.
  - Response: digits 3 and 1 keep AN=1111. Digit 2 is shown with dp=0. Digit 0 shows 5.
- Hex passthrough:
  - Stimulus: a_val=16'hABCD.
  - Response: digit=D,C,B,A in slot order.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Optional feature macro: SEG_SCAN_LZ_BLANK_EN (leading-zero blanking).
package seg_scan_pkg;

    typedef enum logic [1:0] {
        SHOW_A = 2'd0,
        PEND_B = 2'd1,
        SHOW_B = 2'd2
    } scan_state_t;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam logic       DP_OFF     = 1'b1;

    // Pick nibble 'idx' out of a packed four-digit value (digit 0 = [3:0]).
    function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] idx);
        logic [3:0] n;
        case (idx)
            2'd0:    n = v[3:0];
            2'd1:    n = v[7:4];
            2'd2:    n = v[11:8];
            default: n = v[15:12];
        endcase
        return n;
    endfunction

    // Mask of digits that count as leading zeros: zero nibble, no non-zero
    // digit above it, and no decimal point of its own. Digit 0 is never masked.
    function automatic logic [3:0] lz_mask(input logic [15:0] v, input logic [3:0] dpb);
        logic [3:0] m;
        logic       higher_nz;
        m         = 4'b0000;
        higher_nz = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (v[i*4 +: 4] != 4'h0) begin
                higher_nz = 1'b1;
            end else if (!higher_nz && !dpb[i]) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot timer for the display scan: per-slot cycle counter, digit index and
// a strobe marking the last cycle of a complete four-digit frame.
module seg_slot_timer
    import seg_scan_pkg::*;
#(
    parameter int DIGIT_CYCLES = 1024,
    parameter int CW           = $clog2(DIGIT_CYCLES)
) (
    input  logic          CLK,
    input  logic          RST,
    output logic [CW-1:0] slot_cnt,
    output logic [1:0]    digit_idx,
    output logic          frame_end
);

    localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_CYCLES - 1);

    logic slot_wrap;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_wrap && (digit_idx == 2'(NUM_DIGITS - 1));

    // Count cycles within a slot and step to the next digit when the slot wraps.
    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (slot_wrap) begin
            slot_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            slot_cnt  <= slot_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Display scan scheduler: shares a 4-digit active-low seven-segment display
// between live channel A and a latched channel B message, switching owner
// only at frame boundaries. Each slot opens with a blanking interval.
// Optional feature macro: SEG_SCAN_LZ_BLANK_EN (leading-zero blanking).
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int DIGIT_CYCLES = 1024,
    parameter int BLANK_CYCLES = 64,
    parameter int HOLD_FRAMES  = 200
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] a_val,
    input  logic [3:0]  a_dp,
    input  logic        b_req,
    input  logic [15:0] b_val,
    input  logic [3:0]  b_dp,
    output logic        b_ack,
    output logic [3:0]  digit,
    output logic        dp,
    output logic [3:0]  AN,
    output logic        owner
);

    localparam int            CW         = $clog2(DIGIT_CYCLES);
    localparam int            FW         = $clog2(HOLD_FRAMES + 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);
    localparam logic [FW-1:0] LAST_FRAME = FW'(HOLD_FRAMES - 1);

    logic [CW-1:0] slot_cnt;
    logic [1:0]    digit_idx;
    logic          frame_end;

    scan_state_t   state, state_next;
    logic          owner_next;
    logic          ack_next;
    logic          latch_en;
    logic [FW-1:0] frame_cnt, frame_cnt_next;
    logic [15:0]   b_val_q;
    logic [3:0]    b_dp_q;
    logic          rst_q;

    logic [15:0]   src_val;
    logic [3:0]    src_dp;
    logic [3:0]    nib;
    logic          lz_blank;
    logic [3:0]    an_next;
    logic          dp_next;

    seg_slot_timer #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .CW           (CW)
    ) u_timer (
        .CLK       (CLK),
        .RST       (RST),
        .slot_cnt  (slot_cnt),
        .digit_idx (digit_idx),
        .frame_end (frame_end)
    );

    // Remember that the previous edge was in reset so a request held across
    // reset release is not acknowledged on the release cycle.
    always_ff @(posedge CLK) begin
        rst_q <= RST;
    end

    // Ownership FSM: accept a B request, wait for a frame boundary, hold B for
    // a fixed number of frames, then hand the display back to A.
    always_comb begin
        state_next     = state;
        owner_next     = owner;
        ack_next       = 1'b0;
        latch_en       = 1'b0;
        frame_cnt_next = frame_cnt;
        case (state)
            SHOW_A: begin
                if (b_req && !rst_q) begin
                    ack_next   = 1'b1;
                    latch_en   = 1'b1;
                    state_next = PEND_B;
                end
            end
            PEND_B: begin
                if (frame_end) begin
                    owner_next     = 1'b1;
                    frame_cnt_next = '0;
                    state_next     = SHOW_B;
                end
            end
            SHOW_B: begin
                if (frame_end) begin
                    if (frame_cnt == LAST_FRAME) begin
                        owner_next = 1'b0;
                        state_next = SHOW_A;
                    end else begin
                        frame_cnt_next = frame_cnt + FW'(1);
                    end
                end
            end
            default: begin
                state_next = SHOW_A;
                owner_next = 1'b0;
            end
        endcase
    end

    // FSM state register together with the registered owner, ack and frame count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= SHOW_A;
            owner     <= 1'b0;
            b_ack     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            b_ack     <= ack_next;
            frame_cnt <= frame_cnt_next;
        end
    end

    // Capture the channel B message on the edge that raises b_ack; reset discards it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            b_val_q <= 16'h0000;
            b_dp_q  <= 4'h0;
        end else if (latch_en) begin
            b_val_q <= b_val;
            b_dp_q  <= b_dp;
        end
    end

    // Select the owner's source and build next anode/dp values for this slot position.
    always_comb begin
        src_val = owner ? b_val_q : a_val;
        src_dp  = owner ? b_dp_q  : a_dp;
        nib     = nibble_sel(src_val, digit_idx);
`ifdef SEG_SCAN_LZ_BLANK_EN
        lz_blank = lz_mask(src_val, src_dp) [digit_idx];
`else
        lz_blank = 1'b0;
`endif
        an_next = AN_OFF;
        dp_next = DP_OFF;
        if ((slot_cnt >= BLANK_END) && !lz_blank) begin
            an_next = ~(4'b0001 << digit_idx);
            dp_next = ~src_dp[digit_idx];
        end
    end

    // Register the display drive so outputs lag the counter by one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            AN    <= AN_OFF;
            dp    <= DP_OFF;
            digit <= 4'h0;
        end else begin
            AN    <= an_next;
            dp    <= dp_next;
            digit <= nib;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with a shortened scan:
// 8 cycles per slot, 2 blanking cycles, 2-frame channel B hold.
module tb_seg_scan_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] a_val = 16'h0000;
    logic [3:0]  a_dp = 4'h0;
    logic        b_req = 1'b0;
    logic [15:0] b_val = 16'h0000;
    logic [3:0]  b_dp = 4'h0;
    logic        b_ack;
    logic [3:0]  digit;
    logic        dp;
    logic [3:0]  AN;
    logic        owner;

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    seg_scan_ctrl #(
        .DIGIT_CYCLES (8),
        .BLANK_CYCLES (2),
        .HOLD_FRAMES  (2)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .a_val (a_val),
        .a_dp  (a_dp),
        .b_req (b_req),
        .b_val (b_val),
        .b_dp  (b_dp),
        .b_ack (b_ack),
        .digit (digit),
        .dp    (dp),
        .AN    (AN),
        .owner (owner)
    );

    // Free-running 10-unit clock.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    // Advance one edge and settle; k counts edges since reset release.
    task automatic tick();
        @(posedge CLK);
        #1;
        k++;
    endtask

    task automatic runTo(input int target);
        while (k < target) tick();
    endtask

    task automatic applyStimulus(input logic [15:0] av, input logic [3:0] adp);
        a_val = av;
        a_dp  = adp;
    endtask

    task automatic doReset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        k   = 0;
    endtask

    logic [3:0] scanDig [4] = '{4'h5, 4'h1, 4'h0, 4'h0};
    logic [3:0] expAn;
    logic       ackSeen;

    initial begin
        $display("[TB] start");

        // Reset values while RST is held
        applyStimulus(16'h0015, 4'h0);
        RST = 1'b1;
        tick();
        tick();
        checkOutput("rst_an",    {12'h0, AN},    16'h000F);
        checkOutput("rst_dp",    {15'h0, dp},    16'h0001);
        checkOutput("rst_digit", {12'h0, digit}, 16'h0000);
        checkOutput("rst_ack",   {15'h0, b_ack}, 16'h0000);
        checkOutput("rst_owner", {15'h0, owner}, 16'h0000);
        RST = 1'b0;
        k   = 0;

        // Reset scan: two blank cycles then six lit cycles per digit
        for (int n = 1; n <= 32; n++) begin
            tick();
            if (((k - 1) % 8) < 2) expAn = 4'b1111;
            else                   expAn = ~(4'b0001 << ((k - 1) / 8));
            checkOutput("scan_an", {12'h0, AN}, {12'h0, expAn});
            if (((k - 1) % 8) >= 2)
                checkOutput("scan_digit", {12'h0, digit}, {12'h0, scanDig[(k - 1) / 8]});
            checkOutput("scan_dp", {15'h0, dp}, 16'h0001);
        end

        // B request and busy request
        doReset();
        applyStimulus(16'h1234, 4'h0);
        b_val = 16'h0010;
        b_dp  = 4'h0;
        runTo(5);
        checkOutput("ack_idle", {15'h0, b_ack}, 16'h0000);
        b_req = 1'b1;
        tick();
        checkOutput("ack_pulse", {15'h0, b_ack}, 16'h0001);
        b_req = 1'b0;
        b_val = 16'hFFFF;
        b_dp  = 4'hF;
        tick();
        checkOutput("ack_one_cycle", {15'h0, b_ack}, 16'h0000);
        runTo(31);
        checkOutput("owner_pend", {15'h0, owner}, 16'h0000);
        tick();
        checkOutput("owner_rise", {15'h0, owner}, 16'h0001);
        runTo(35);
        checkOutput("b_an0",    {12'h0, AN},    16'h000E);
        checkOutput("b_digit0", {12'h0, digit}, 16'h0000);
        checkOutput("b_dp0",    {15'h0, dp},    16'h0001);
        runTo(40);
        b_req   = 1'b1;
        b_val   = 16'h0777;
        b_dp    = 4'h0;
        ackSeen = 1'b0;
        while (k < 96) begin
            tick();
            if (b_ack) ackSeen = 1'b1;
            if (k == 43) begin
                checkOutput("b_an1",    {12'h0, AN},    16'h000D);
                checkOutput("b_digit1", {12'h0, digit}, 16'h0001);
            end
            if (k == 64) checkOutput("owner_hold", {15'h0, owner}, 16'h0001);
            if (k == 95) checkOutput("owner_last", {15'h0, owner}, 16'h0001);
        end
        checkOutput("busy_no_ack", {15'h0, ackSeen}, 16'h0000);
        checkOutput("owner_fall",  {15'h0, owner},   16'h0000);
        tick();
        checkOutput("busy_ack", {15'h0, b_ack}, 16'h0001);
        b_req = 1'b0;
        tick();
        checkOutput("busy_ack_one", {15'h0, b_ack}, 16'h0000);
        runTo(99);
        checkOutput("a_after_b", {12'h0, digit}, 16'h0004);
        runTo(127);
        checkOutput("owner_pend2", {15'h0, owner}, 16'h0000);
        tick();
        checkOutput("owner_second", {15'h0, owner}, 16'h0001);
        runTo(131);
        checkOutput("b2_digit0", {12'h0, digit}, 16'h0007);

        // Reset mid-message, request held across reset release
        RST   = 1'b1;
        b_req = 1'b1;
        applyStimulus(16'hABCD, 4'h0);
        tick();
        checkOutput("mid_owner", {15'h0, owner}, 16'h0000);
        checkOutput("mid_an",    {12'h0, AN},    16'h000F);
        checkOutput("mid_dp",    {15'h0, dp},    16'h0001);
        checkOutput("mid_digit", {12'h0, digit}, 16'h0000);
        checkOutput("mid_ack",   {15'h0, b_ack}, 16'h0000);
        RST = 1'b0;
        k   = 0;
        tick();
        checkOutput("release_no_ack", {15'h0, b_ack}, 16'h0000);
        b_req = 1'b0;
        tick();
        checkOutput("release_no_ack2", {15'h0, b_ack}, 16'h0000);

        // Hex passthrough after restart
        runTo(3);
        checkOutput("hex_an0", {12'h0, AN},    16'h000E);
        checkOutput("hex_d0",  {12'h0, digit}, 16'h000D);
        runTo(11);
        checkOutput("hex_d1",  {12'h0, digit}, 16'h000C);
        runTo(19);
        checkOutput("hex_d2",  {12'h0, digit}, 16'h000B);
        runTo(27);
        checkOutput("hex_an3", {12'h0, AN},    16'h0007);
        checkOutput("hex_d3",  {12'h0, digit}, 16'h000A);
        runTo(40);
        checkOutput("msg_discarded", {15'h0, owner}, 16'h0000);

        // Leading zeros with a decimal point on digit 2
        doReset();
        applyStimulus(16'h0005, 4'b0100);
        runTo(3);
        checkOutput("lz_an0",    {12'h0, AN},    16'h000E);
        checkOutput("lz_digit0", {12'h0, digit}, 16'h0005);
        checkOutput("lz_dp0",    {15'h0, dp},    16'h0001);
        runTo(11);
`ifdef SEG_SCAN_LZ_BLANK_EN
        checkOutput("lz_an1", {12'h0, AN}, 16'h000F);
        runTo(16);
        checkOutput("lz_an1_end", {12'h0, AN}, 16'h000F);
`else
        checkOutput("lz_an1",    {12'h0, AN},    16'h000D);
        checkOutput("lz_digit1", {12'h0, digit}, 16'h0000);
        runTo(16);
        checkOutput("lz_an1_end", {12'h0, AN}, 16'h000D);
`endif
        runTo(19);
        checkOutput("lz_an2", {12'h0, AN}, 16'h000B);
        checkOutput("lz_dp2", {15'h0, dp}, 16'h0000);
        runTo(27);
`ifdef SEG_SCAN_LZ_BLANK_EN
        checkOutput("lz_an3", {12'h0, AN}, 16'h000F);
`else
        checkOutput("lz_an3",    {12'h0, AN},    16'h0007);
        checkOutput("lz_digit3", {12'h0, digit}, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
